myvga_axil_slave_regs: RTL and testbench
========================================

Name: myvga_axil_slave_regs

Overview:
- AXI4-Lite responder (slave) for the myVGA IP: the register-file end of the S00_AXI interface that the master VIP drives.
- Holds four 32-bit read/write registers (REG0..REG3 at offsets 0x0, 0x4, 0x8, 0xC).
- Exposes the registers and per-register write pulses to the VGA timing/pixel logic.
- Supports AW and W arriving in either order, byte strobes, and one outstanding write and one outstanding read in flight concurrently.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3 (ignored).
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1.
- reg0_o..reg3_o  out  32 each  current register contents.
- reg_wr_pulse_o  out  4  one-cycle pulse, bit n set when REGn is written.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All registers 0; all VALIDs 0.
  - BRESP = RRESP = 2'b00; RDATA = 0; reg_wr_pulse_o = 0.
  - AW/W buffers marked empty.
- Reset mid-transaction discards any buffered address/data and pending responses. No partial register update.
- Write path:
  - Separate AW buffer and W buffer, each one entry (full flag, registered contents).
  - AWREADY = !aw_full && !BVALID (combinational). WREADY = !w_full && !BVALID.
  - AW handshake loads the AW buffer; W handshake loads the W buffer. Same-edge loading of both is allowed.
  - Edge after both are full (commit edge):
    - For each byte lane i with WSTRB[i]=1, REG[AWADDR[3:2]] byte i <= WDATA byte i; lanes with WSTRB[i]=0 are unchanged.
    - Set BVALID=1, BRESP=OKAY, and the matching reg_wr_pulse_o bit for that cycle only.
    - Clear both buffers.
  - Minimum latency: AW+W handshake at edge E -> register update and BVALID at E+1.
  - WSTRB=0 still commits and responds: no byte changes, pulse still asserted.
  - BVALID held until the BREADY handshake. BVALID deasserts on the handshake edge.
  - No new AW/W is accepted while BVALID=1.
  - BREADY low for N cycles stalls the write channels for N cycles.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake at edge E: RDATA <= REG[ARADDR[3:2]] (value before any commit at E); RVALID=1 and RRESP=OKAY from E.
  - RDATA and RVALID are stable until the RREADY handshake. The next AR is accepted the cycle after RVALID drops.
  - Back-to-back with RREADY tied high: one read per 2 cycles.
- Simultaneous read and write to the same register on the same edge: the read returns the old value. A read accepted at or after the edge following the commit edge returns the new value.
- Read and write channels are fully independent; neither blocks the other.
- All responses are OKAY. No address is out of range (aliasing by [3:2]).

Test Plan:
- Sequential write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all BRESP/RRESP = 00, reg_wr_pulse_o = 0001,0010,0100,1000 in turn.
- W valid 3 cycles before AW (data 0xDEADBEEF, addr 0x8) -> WREADY drops after the W handshake, commit the edge after AW, reg2_o = 0xDEADBEEF; repeat with AW first -> same result.
- REG1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read 0x4 returns 0xFF34FF78; WSTRB=0 -> value unchanged, pulse bit1 still fires.
- Hold BREADY low 5 cycles after a write -> BVALID stays 1, AWREADY/WREADY stay 0 for 5 cycles; a second write is accepted only after the B handshake.
- Read 0xC and write 0xAAAA5555 to 0xC on the same edge (old 0x4) -> RDATA=0x4; next read returns 0xAAAA5555.
- Assert ARESETN=0 with AW buffered and RVALID=1 -> all VALIDs 0 immediately, regs 0; a post-reset read of 0x0 returns 0.

Source files
------------

// File: rtl/myvga_axil_slave_regs.sv
// AXI4-Lite register file for the myVGA IP: four 32-bit read/write registers
// with byte strobes, exported to the VGA timing/pixel logic together with a
// one-cycle write pulse per register.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both VALID and READY are high. A source keeps VALID and its payload
// stable until that edge. READY may depend combinationally on internal state
// but never on the VALID of the same channel.
module myvga_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    // write response channel
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    // register outputs toward the VGA logic
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic [3:0]                        reg_wr_pulse_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] regs [4];

    logic          aw_full;
    logic [1:0]    aw_idx;
    logic          w_full;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;

    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [3:0]    wr_pulse_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          b_hs;
    logic          r_hs;
    logic          commit;
    logic [DW-1:0] merged;

    // Protection bits and the byte offset inside a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Handshakes and ready signals
    // ------------------------------------------------------------------
    // Both write buffers refuse new entries while a response is still
    // waiting, so at most one write is ever in flight.
    assign S_AXI_AWREADY = !aw_full && !bvalid_q;
    assign S_AXI_WREADY  = !w_full  && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign b_hs   = bvalid_q && S_AXI_BREADY;
    assign r_hs   = rvalid_q && S_AXI_RREADY;

    // A write commits on the first edge where address and data are both held.
    assign commit = aw_full && w_full;

    // ------------------------------------------------------------------
    // Write address buffer
    // ------------------------------------------------------------------
    // Capture the target register index; emptied on the commit edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            aw_idx  <= 2'd0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[3:2];
        end
    end

    // ------------------------------------------------------------------
    // Write data buffer
    // ------------------------------------------------------------------
    // Capture data and strobes; emptied on the commit edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Merge strobed bytes of the buffered data into the current register value.
    always_comb begin
        merged = regs[aw_idx];
        for (int i = 0; i < SW; i++) begin
            if (w_strb_q[i]) begin
                merged[8*i +: 8] = w_data_q[8*i +: 8];
            end
        end
    end

    // Update the addressed register on the commit edge only.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[aw_idx] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // Write response and write pulse
    // ------------------------------------------------------------------
    // BVALID rises with the commit and holds until the master takes it.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bvalid_q <= 1'b0;
        end else if (commit) begin
            bvalid_q <= 1'b1;
        end else if (b_hs) begin
            bvalid_q <= 1'b0;
        end
    end

    // One-cycle pulse naming the register that changed on the commit edge;
    // fires even for an all-zero strobe so the consumer sees every write.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_pulse_q <= 4'b0000;
        end else if (commit) begin
            wr_pulse_q <= 4'b0001 << aw_idx;
        end else begin
            wr_pulse_q <= 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Sample the register on the AR edge; a commit on that same edge is not
    // yet visible, so the old value is returned.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= regs[S_AXI_ARADDR[3:2]];
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_BRESP    = RESP_OKAY;
    assign S_AXI_BVALID   = bvalid_q;
    assign S_AXI_RRESP    = RESP_OKAY;
    assign S_AXI_RVALID   = rvalid_q;
    assign S_AXI_RDATA    = rdata_q;
    assign reg_wr_pulse_o = wr_pulse_q;
    assign reg0_o         = regs[0];
    assign reg1_o         = regs[1];
    assign reg2_o         = regs[2];
    assign reg3_o         = regs[3];

endmodule

// File: tb/tb_myvga_axil_slave_regs.sv
// Directed bench for the myVGA AXI4-Lite register file.
module tb_myvga_axil_slave_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;

  int n_checks;
  int n_errors;

  myvga_axil_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .reg_wr_pulse_o(wr_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drive one write on AW and W together; returns once both are accepted
  task automatic send_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_go, w_go;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick();
      n++;
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
  endtask

  // wait for the write response, check it and the pulse, then see it retire
  task automatic wait_bresp(input logic [3:0] exp_pulse);
    int n;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    check("bvalid", {31'd0, bvalid}, 32'd1);
    check("bresp", {30'd0, bresp}, 32'd0);
    check("wr_pulse", {28'd0, wr_pulse}, {28'd0, exp_pulse});
    bready = 1'b1;
    tick();
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
    check("wr_pulse_drop", {28'd0, wr_pulse}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    logic go;
    int n;
    araddr = a; arvalid = 1'b1;
    go = 1'b0; n = 0;
    while (!go && n < 20) begin
      go = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check("rd_handshake", {31'd0, go}, 32'd1);
    check("rvalid", {31'd0, rvalid}, 32'd1);
    check("rdata", rdata, exp);
    check("rresp", {30'd0, rresp}, 32'd0);
    rready = 1'b1;
    tick();
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b1;
    tick(); tick();

    // reset state
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_pulse", {28'd0, wr_pulse}, 32'd0);
    check("rst_reg0", reg0, 32'd0);
    check("rst_reg3", reg3, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_awready", {31'd0, awready}, 32'd1);
    check("rst_wready", {31'd0, wready}, 32'd1);
    check("rst_arready", {31'd0, arready}, 32'd1);

    // sequential writes and read back
    send_write(4'h0, 32'h1, 4'hF); wait_bresp(4'b0001);
    send_write(4'h4, 32'h2, 4'hF); wait_bresp(4'b0010);
    send_write(4'h8, 32'h3, 4'hF); wait_bresp(4'b0100);
    send_write(4'hC, 32'h4, 4'hF); wait_bresp(4'b1000);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_read(4'hC, 32'h4);
    check("reg1_out", reg1, 32'h2);

    // W three cycles ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready", {31'd0, wready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wfirst_hold_reg2", reg2, 32'h3);
      check("wfirst_hold_bvalid", {31'd0, bvalid}, 32'd0);
    end
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_aw_edge_reg2", reg2, 32'h3);
    tick();
    check("wfirst_commit_reg2", reg2, 32'hDEADBEEF);
    check("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    check("wfirst_pulse", {28'd0, wr_pulse}, 32'b0100);
    tick();
    check("wfirst_bdone", {31'd0, bvalid}, 32'd0);

    // AW three cycles ahead of W
    send_write(4'h8, 32'h0, 4'hF); wait_bresp(4'b0100);
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("awfirst_awready", {31'd0, awready}, 32'd0);
    tick(); tick();
    check("awfirst_hold_reg2", reg2, 32'h0);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    check("awfirst_commit_reg2", reg2, 32'hDEADBEEF);
    check("awfirst_pulse", {28'd0, wr_pulse}, 32'b0100);
    tick();

    // byte strobes
    send_write(4'h4, 32'hFFFFFFFF, 4'hF); wait_bresp(4'b0010);
    send_write(4'h4, 32'h12345678, 4'b0101); wait_bresp(4'b0010);
    axi_read(4'h4, 32'hFF34FF78);
    send_write(4'h5, 32'h00000000, 4'b0000); wait_bresp(4'b0010);
    axi_read(4'h4, 32'hFF34FF78);

    // BREADY held low stalls the write channels
    bready = 1'b0;
    send_write(4'h0, 32'h55, 4'hF);
    tick();
    awaddr = 4'h4; awvalid = 1'b1; wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_bvalid", {31'd0, bvalid}, 32'd1);
      check("stall_awready", {31'd0, awready}, 32'd0);
      check("stall_wready", {31'd0, wready}, 32'd0);
      tick();
    end
    check("stall_reg1", reg1, 32'hFF34FF78);
    bready = 1'b1;
    tick();
    check("stall_bdone", {31'd0, bvalid}, 32'd0);
    check("stall_awready_back", {31'd0, awready}, 32'd1);
    check("stall_wready_back", {31'd0, wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bresp(4'b0010);
    check("stall_reg0", reg0, 32'h55);
    check("stall_reg1_new", reg1, 32'h66);

    // read and commit on the same edge
    awaddr = 4'hC; wdata = 32'hAAAA5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    check("same_awready", {31'd0, awready}, 32'd1);
    check("same_wready", {31'd0, wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("same_rvalid", {31'd0, rvalid}, 32'd1);
    check("same_rdata_old", rdata, 32'h4);
    check("same_reg3_new", reg3, 32'hAAAA5555);
    check("same_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    axi_read(4'hC, 32'hAAAA5555);

    // asynchronous reset with AW buffered and a read response pending
    rready = 1'b0;
    awaddr = 4'h0; awvalid = 1'b1;
    araddr = 4'hC; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("prerst_rvalid", {31'd0, rvalid}, 32'd1);
    check("prerst_awready", {31'd0, awready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_bvalid", {31'd0, bvalid}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    check("arst_reg0", reg0, 32'd0);
    check("arst_reg3", reg3, 32'd0);
    check("arst_awready", {31'd0, awready}, 32'd1);
    tick();
    rst_n = 1'b1;
    rready = 1'b1;
    tick();
    // a lone W must not pair with the address that reset discarded
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_no_commit", {31'd0, bvalid}, 32'd0);
    end
    axi_read(4'h0, 32'h0);
    awaddr = 4'h0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_bresp(4'b0001);
    check("postrst_reg0", reg0, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
